// File: rtl/alu_pkg.sv
// Shared opcode encoding for the accumulator ALU and its writeback stage.
// Latency: none (types and constants only).
// Backpressure: none.
package alu_pkg;

  localparam int DW_DEF = 8;

  typedef enum logic [3:0] {
    OP_SHIFT = 4'b0000,
    OP_BR0   = 4'b0001,
    OP_BR1   = 4'b0010,
    OP_BR2   = 4'b0011,
    OP_LOAD  = 4'b0100,
    OP_STORE = 4'b0101,
    OP_PUSH  = 4'b0110,
    OP_POP   = 4'b0111,
    OP_AND   = 4'b1000,
    OP_OR    = 4'b1001,
    OP_XOR   = 4'b1010,
    OP_NOT   = 4'b1011,
    OP_ADD   = 4'b1100,
    OP_SUB   = 4'b1101,
    OP_RSVD  = 4'b1110,
    OP_ACK   = 4'b1111
  } alu_op_t;

endpackage

// File: rtl/lifo_stack.sv
// Operand LIFO: saturating push/pop with a one-cycle error pulse on overflow/underflow.
// Latency: count/top update on the edge after push/pop; dout reads the current top combinationally from storage.
// Backpressure: none; a push when full or a pop when empty is dropped and flagged on err_pulse.
// Ports: clk, rst_n (async active-low); push, pop, din in; dout, count, full, empty, err_pulse out.
// Macro STK_PEEK_EN adds a registered 'top' output (0 when empty).
module lifo_stack #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [PW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          err_pulse
`ifdef STK_PEEK_EN
  ,
  output logic [DW-1:0] top
`endif
);

  localparam int IW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  assign full      = (count == PW'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign err_pulse = (push && full) || (pop && empty);

  // count < DEPTH whenever a push is accepted, so the truncated index is exact.
  assign wr_idx = IW'(count);
  assign rd_idx = IW'(count - PW'(1));
  assign dout   = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (do_push) begin
      count <= count + PW'(1);
    end else if (do_pop) begin
      count <= count - PW'(1);
    end
  end

`ifdef STK_PEEK_EN
  logic [IW-1:0] below_idx;
  assign below_idx = IW'(count - PW'(2));

  // After a pop the new top is the entry beneath the current one, or 0 if the stack drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top <= '0;
    end else if (do_push) begin
      top <= din;
    end else if (do_pop) begin
      top <= (count >= PW'(2)) ? mem[below_idx] : '0;
    end
  end
`endif

endmodule

// File: rtl/acc_stack_unit.sv
// Writeback stage: latches ALU result into acc/carry/zero/parity and drives the push/pop operand stack.
// Latency: 1 cycle from committed ALU inputs to acc/flags/stack outputs; all outputs registered.
// Backpressure: none; stack overflow/underflow drops the op and sets sticky stk_err (cleared by ACK).
// Ports: clk, rst_n; wr_en, alu_op, alu_result, alu_cout in;
//        acc, carry, flag_zero, flag_pari, stk_count, stk_full, stk_empty, stk_err out.
// Macro STK_PEEK_EN adds output stk_top (registered top-of-stack, 0 when empty).
module acc_stack_unit
  import alu_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [3:0]    alu_op,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_cout,
  output logic [DW-1:0] acc,
  output logic          carry,
  output logic          flag_zero,
  output logic          flag_pari,
  output logic [PW-1:0] stk_count,
  output logic          stk_full,
  output logic          stk_empty,
  output logic          stk_err
`ifdef STK_PEEK_EN
  ,
  output logic [DW-1:0] stk_top
`endif
);

  alu_op_t       op;
  logic          push;
  logic          pop;
  logic          err_pulse;
  logic [DW-1:0] stk_dout;
  logic          acc_we;
  logic          carry_we;
  logic          ack;
  logic [DW-1:0] acc_nxt;

  assign op = alu_op_t'(alu_op);

  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    acc_we   = 1'b0;
    carry_we = 1'b0;
    ack      = 1'b0;
    acc_nxt  = alu_result;
    if (wr_en) begin
      unique case (op)
        OP_SHIFT, OP_ADD, OP_SUB: begin
          acc_we   = 1'b1;
          carry_we = 1'b1;
        end
        OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LOAD: acc_we = 1'b1;
        OP_PUSH: push = 1'b1;
        OP_POP: begin
          pop     = 1'b1;
          acc_we  = !stk_empty;
          acc_nxt = stk_dout;
        end
        OP_ACK: ack = 1'b1;
        default: ;
      endcase
    end
  end

  lifo_stack #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .din       (alu_result),
    .dout      (stk_dout),
    .count     (stk_count),
    .full      (stk_full),
    .empty     (stk_empty),
    .err_pulse (err_pulse)
`ifdef STK_PEEK_EN
    ,
    .top       (stk_top)
`endif
  );

  // Flags are derived from the value being written, not from the ALU's own flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      carry     <= 1'b0;
      flag_zero <= 1'b1;
      flag_pari <= 1'b0;
      stk_err   <= 1'b0;
    end else begin
      if (ack) begin
        acc       <= '0;
        carry     <= 1'b0;
        flag_zero <= 1'b1;
        flag_pari <= 1'b0;
        stk_err   <= 1'b0;
      end else begin
        if (acc_we) begin
          acc       <= acc_nxt;
          flag_zero <= (acc_nxt == '0);
          flag_pari <= ^acc_nxt;
        end
        if (carry_we) carry <= alu_cout;
        if (err_pulse) stk_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_acc_stack_unit.sv
module tb_acc_stack_unit;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int PW    = $clog2(DEPTH) + 1;

  localparam logic [3:0] SHIFT = 4'b0000, BR1 = 4'b0010, LOAD = 4'b0100,
                         PUSH  = 4'b0110, POP = 4'b0111, AND_ = 4'b1000,
                         ADD   = 4'b1100, SUB = 4'b1101, ACK  = 4'b1111;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [3:0]    alu_op = 4'b0;
  logic [DW-1:0] alu_result = '0;
  logic          alu_cout = 1'b0;
  logic [DW-1:0] acc;
  logic          carry, flag_zero, flag_pari, stk_full, stk_empty, stk_err;
  logic [PW-1:0] stk_count;
`ifdef STK_PEEK_EN
  logic [DW-1:0] stk_top;
`endif

  int checks = 0;
  int failures = 0;

  acc_stack_unit #(.DW(DW), .DEPTH(DEPTH), .PW(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .acc        (acc),
    .carry      (carry),
    .flag_zero  (flag_zero),
    .flag_pari  (flag_pari),
    .stk_count  (stk_count),
    .stk_full   (stk_full),
    .stk_empty  (stk_empty),
    .stk_err    (stk_err)
`ifdef STK_PEEK_EN
    ,
    .stk_top    (stk_top)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one instruction between edges, let it commit, sample 1ns after the edge.
  task automatic issue(input logic we, input logic [3:0] op, input logic [DW-1:0] res,
                       input logic co);
    @(negedge clk);
    wr_en      = we;
    alu_op     = op;
    alu_result = res;
    alu_cout   = co;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic check_peek(input string tag, input logic [DW-1:0] exp);
`ifdef STK_PEEK_EN
    check(tag, 32'(stk_top), 32'(exp));
`else
    if (exp === 'x) $display("peek %s unused", tag);
`endif
  endtask

  initial begin
    // Asynchronous reset assertion mid-cycle.
    #3 rst_n = 1'b0;
    #1;
    check("rst_acc", 32'(acc), 32'h00);
    check("rst_carry", 32'(carry), 0);
    check("rst_zero", 32'(flag_zero), 1);
    check("rst_pari", 32'(flag_pari), 0);
    check("rst_empty", 32'(stk_empty), 1);
    check("rst_full", 32'(stk_full), 0);
    check("rst_count", 32'(stk_count), 0);
    check("rst_err", 32'(stk_err), 0);
    check_peek("rst_top", 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD then AND: carry kept across a logic op.
    issue(1'b1, ADD, 8'h07, 1'b1);
    check("add_acc", 32'(acc), 32'h07);
    check("add_carry", 32'(carry), 1);
    check("add_zero", 32'(flag_zero), 0);
    check("add_pari", 32'(flag_pari), 1);
    issue(1'b1, AND_, 8'h00, 1'b0);
    check("and_acc", 32'(acc), 32'h00);
    check("and_carry", 32'(carry), 1);
    check("and_zero", 32'(flag_zero), 1);
    check("and_pari", 32'(flag_pari), 0);

    // No commit, then a branch: nothing changes.
    issue(1'b0, ADD, 8'hFF, 1'b0);
    check("nowr_acc", 32'(acc), 32'h00);
    check("nowr_carry", 32'(carry), 1);
    check("nowr_zero", 32'(flag_zero), 1);
    issue(1'b1, BR1, 8'h55, 1'b0);
    check("br_acc", 32'(acc), 32'h00);
    check("br_carry", 32'(carry), 1);

    // LOAD holds carry; SUB and SHIFT update it.
    issue(1'b1, LOAD, 8'h03, 1'b0);
    check("ld_acc", 32'(acc), 32'h03);
    check("ld_pari", 32'(flag_pari), 0);
    check("ld_carry", 32'(carry), 1);
    issue(1'b1, SUB, 8'h80, 1'b0);
    check("sub_acc", 32'(acc), 32'h80);
    check("sub_carry", 32'(carry), 0);
    check("sub_pari", 32'(flag_pari), 1);
    issue(1'b1, SHIFT, 8'hFE, 1'b1);
    check("shf_carry", 32'(carry), 1);
    check("shf_pari", 32'(flag_pari), 1);

    // LIFO order with three entries; acc held during pushes.
    issue(1'b1, PUSH, 8'h11, 1'b0);
    issue(1'b1, PUSH, 8'h22, 1'b0);
    issue(1'b1, PUSH, 8'h33, 1'b0);
    check("push_acc_held", 32'(acc), 32'hFE);
    check("push_count", 32'(stk_count), 3);
    check_peek("push_top", 8'h33);
    issue(1'b1, POP, 8'h00, 1'b0);
    check("pop1_acc", 32'(acc), 32'h33);
    check("pop1_count", 32'(stk_count), 2);
    check("pop1_pari", 32'(flag_pari), 0);
    check_peek("pop1_top", 8'h22);
    issue(1'b1, POP, 8'h00, 1'b0);
    check("pop2_acc", 32'(acc), 32'h22);
    check_peek("pop2_top", 8'h11);
    issue(1'b1, POP, 8'h00, 1'b0);
    check("pop3_acc", 32'(acc), 32'h11);
    check("pop3_count", 32'(stk_count), 0);
    check("pop3_empty", 32'(stk_empty), 1);
    check("pop3_err", 32'(stk_err), 0);
    check_peek("pop3_top", 8'h00);

    // Fill to DEPTH, then overflow.
    for (int i = 0; i < DEPTH; i++) issue(1'b1, PUSH, 8'hA0 + 8'(i), 1'b0);
    check("fill_full", 32'(stk_full), 1);
    check("fill_count", 32'(stk_count), DEPTH);
    check("fill_err", 32'(stk_err), 0);
    issue(1'b1, PUSH, 8'hA8, 1'b0);
    check("ovf_err", 32'(stk_err), 1);
    check("ovf_count", 32'(stk_count), DEPTH);
    check_peek("ovf_top", 8'hA7);
    issue(1'b1, POP, 8'h00, 1'b0);
    check("ovf_pop_acc", 32'(acc), 32'hA7);
    check("ovf_pop_pari", 32'(flag_pari), 1);
    check("ovf_pop_count", 32'(stk_count), DEPTH - 1);
    check("err_sticky", 32'(stk_err), 1);

    // ACK clears error/acc/carry, leaves the stack alone.
    issue(1'b1, ACK, 8'h5A, 1'b1);
    check("ack_err", 32'(stk_err), 0);
    check("ack_acc", 32'(acc), 32'h00);
    check("ack_carry", 32'(carry), 0);
    check("ack_zero", 32'(flag_zero), 1);
    check("ack_count", 32'(stk_count), DEPTH - 1);
    check_peek("ack_top", 8'hA6);

    // Drain, then underflow.
    for (int i = 0; i < DEPTH - 1; i++) issue(1'b1, POP, 8'h00, 1'b0);
    check("drain_acc", 32'(acc), 32'hA0);
    check("drain_empty", 32'(stk_empty), 1);
    check("drain_err", 32'(stk_err), 0);
    issue(1'b1, POP, 8'h00, 1'b0);
    check("unf_acc", 32'(acc), 32'hA0);
    check("unf_err", 32'(stk_err), 1);
    check("unf_count", 32'(stk_count), 0);

    // Reset mid-cycle with a committed push pending: the write is discarded.
    issue(1'b1, LOAD, 8'h3C, 1'b0);
    @(negedge clk);
    wr_en      = 1'b1;
    alu_op     = PUSH;
    alu_result = 8'h77;
    #2 rst_n = 1'b0;
    #1;
    check("mrst_acc", 32'(acc), 32'h00);
    check("mrst_err", 32'(stk_err), 0);
    @(posedge clk);
    #1;
    check("mrst_count", 32'(stk_count), 0);
    check("mrst_empty", 32'(stk_empty), 1);
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, POP, 8'h00, 1'b0);
    check("mrst_pop_err", 32'(stk_err), 1);
    check("mrst_pop_acc", 32'(acc), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
